// File: rtl/int_ctrl.sv
// int_ctrl: 4-line rising-edge interrupt controller with mask, pending,
// fixed priority (bit 0 highest) and vectored handler address.
// Ports:
//   clk, rst (sync, active-high)
//   irq_in[3:0]      : interrupt lines
//   mask_we/wdata    : mask register write
//   int_ack, eret    : CPU accept / handler return
//   INT, int_id, int_vec, mask, pending : registered outputs
module int_ctrl #(
   parameter logic [31:0] VEC_BASE  = 32'h0000_0040,
   parameter int unsigned VEC_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  irq_in,
   input  logic        mask_we,
   input  logic [3:0]  mask_wdata,
   input  logic        int_ack,
   input  logic        eret,
   output logic        INT,
   output logic [1:0]  int_id,
   output logic [31:0] int_vec,
   output logic [3:0]  mask,
   output logic [3:0]  pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  irq_prev_q;
   logic [3:0]  pending_q, pending_d;
   logic [3:0]  mask_q, mask_d;
   logic        int_q, int_d;
   logic [1:0]  int_id_q, int_id_d;
   logic [31:0] int_vec_q, int_vec_d;

   logic [3:0]  irq_rise;
   logic [3:0]  active;
   logic [3:0]  clr;
   logic [1:0]  low_id;

   always_comb begin
      irq_rise = irq_in & ~irq_prev_q;
      active   = pending_q & mask_q;

      if (active[0])      low_id = 2'd0;
      else if (active[1]) low_id = 2'd1;
      else if (active[2]) low_id = 2'd2;
      else                low_id = 2'd3;

      // Only an ack taken in REQ clears; a fresh edge wins over it.
      clr = 4'b0000;
      if (state_q == REQ && int_ack)
         clr = 4'b0001 << int_id_q;
      pending_d = (pending_q & ~clr) | irq_rise;

      mask_d = mask_we ? mask_wdata : mask_q;

      state_d  = state_q;
      int_id_d = int_id_q;
      unique case (state_q)
         IDLE: begin
            if (|active) begin
               state_d  = REQ;
               int_id_d = low_id;
            end
         end
         REQ: begin
            // Ack beats withdrawal when both happen together.
            if (int_ack)
               state_d = SERVICE;
            else if (!mask_q[int_id_q] || !pending_q[int_id_q])
               state_d = IDLE;
         end
         SERVICE: begin
            if (eret)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      int_d     = (state_d == REQ);
      int_vec_d = VEC_BASE + (32'(int_id_d) << VEC_SHIFT);
   end

   always_ff @(posedge clk) begin
      // irq_prev tracks the lines even in reset so a held line
      // does not look like a new edge on release.
      irq_prev_q <= irq_in;
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 4'h0;
         mask_q    <= 4'hF;
         int_q     <= 1'b0;
         int_id_q  <= 2'd0;
         int_vec_q <= VEC_BASE;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         int_q     <= int_d;
         int_id_q  <= int_id_d;
         int_vec_q <= int_vec_d;
      end
   end

   assign INT     = int_q;
   assign int_id  = int_id_q;
   assign int_vec = int_vec_q;
   assign mask    = mask_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed-step bench for int_ctrl.
// Inputs change 1 ns after each rising edge; outputs are checked there.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        int_ack;
   logic        eret;
   logic        INT;
   logic [1:0]  int_id;
   logic [31:0] int_vec;
   logic [3:0]  mask;
   logic [3:0]  pending;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   int_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .int_ack    (int_ack),
      .eret       (eret),
      .INT        (INT),
      .int_id     (int_id),
      .int_vec    (int_vec),
      .mask       (mask),
      .pending    (pending)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; irq_in = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0;
      int_ack = 1'b0; eret = 1'b0;
      tick(); tick();
      chk("rst_int", 32'(INT), 32'h0);
      chk("rst_id", 32'(int_id), 32'h0);
      chk("rst_vec", int_vec, 32'h40);
      chk("rst_mask", 32'(mask), 32'hF);
      chk("rst_pend", 32'(pending), 32'h0);
      rst = 1'b0;
      tick();

      // single source, no ack
      irq_in = 4'b0001;
      tick();
      chk("s1_pend", 32'(pending), 32'h1);
      chk("s1_int_k", 32'(INT), 32'h0);
      tick();
      chk("s1_int", 32'(INT), 32'h1);
      chk("s1_id", 32'(int_id), 32'h0);
      chk("s1_vec", int_vec, 32'h40);
      tick();
      chk("s1_hold", 32'(INT), 32'h1);
      int_ack = 1'b1;
      tick();
      chk("s1_ack_int", 32'(INT), 32'h0);
      chk("s1_ack_pend", 32'(pending), 32'h0);
      int_ack = 1'b0; irq_in = 4'h0; eret = 1'b1;
      tick();
      eret = 1'b0;
      tick();
      chk("s1_idle", 32'(INT), 32'h0);

      // two sources, priority and back-to-back
      irq_in = 4'b1010;
      tick();
      chk("s2_pend", 32'(pending), 32'hA);
      tick();
      chk("s2_int", 32'(INT), 32'h1);
      chk("s2_id", 32'(int_id), 32'h1);
      chk("s2_vec", int_vec, 32'h50);
      int_ack = 1'b1;
      tick();
      chk("s2_ack_int", 32'(INT), 32'h0);
      chk("s2_ack_pend", 32'(pending), 32'h8);
      chk("s2_id_hold", 32'(int_id), 32'h1);
      int_ack = 1'b0;
      tick();
      chk("s2_svc_noint", 32'(INT), 32'h0);
      eret = 1'b1;
      tick();
      chk("s2_eret_int", 32'(INT), 32'h0);
      eret = 1'b0;
      tick();
      chk("s2_b2b_int", 32'(INT), 32'h1);
      chk("s2_b2b_id", 32'(int_id), 32'h3);
      chk("s2_b2b_vec", int_vec, 32'h70);
      int_ack = 1'b1;
      tick();
      chk("s2_ack2_pend", 32'(pending), 32'h0);
      int_ack = 1'b0; eret = 1'b1;
      tick();
      eret = 1'b0; irq_in = 4'h0;
      tick();

      // masked source, then unmask
      mask_we = 1'b1; mask_wdata = 4'b1110;
      tick();
      chk("s3_mask", 32'(mask), 32'hE);
      mask_we = 1'b0; irq_in = 4'b0001;
      tick();
      chk("s3_pend", 32'(pending), 32'h1);
      tick();
      chk("s3_masked1", 32'(INT), 32'h0);
      tick();
      chk("s3_masked2", 32'(INT), 32'h0);
      mask_we = 1'b1; mask_wdata = 4'hF;
      tick();
      chk("s3_mask_f", 32'(mask), 32'hF);
      chk("s3_int_edge", 32'(INT), 32'h0);
      mask_we = 1'b0;
      tick();
      chk("s3_int", 32'(INT), 32'h1);
      chk("s3_id", 32'(int_id), 32'h0);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0; eret = 1'b1;
      tick();
      eret = 1'b0; irq_in = 4'h0;
      tick();

      // withdrawal by masking, then ack beating withdrawal
      irq_in = 4'b0100;
      tick();
      chk("s4_pend", 32'(pending), 32'h4);
      tick();
      chk("s4_int", 32'(INT), 32'h1);
      chk("s4_id", 32'(int_id), 32'h2);
      chk("s4_vec", int_vec, 32'h60);
      mask_we = 1'b1; mask_wdata = 4'b1011;
      tick();
      mask_we = 1'b0;
      tick();
      chk("s4_wd_int", 32'(INT), 32'h0);
      chk("s4_wd_pend", 32'(pending), 32'h4);
      tick();
      chk("s4_wd_stay", 32'(INT), 32'h0);
      mask_we = 1'b1; mask_wdata = 4'hF;
      tick();
      mask_we = 1'b0;
      tick();
      chk("s4_re_int", 32'(INT), 32'h1);
      chk("s4_re_id", 32'(int_id), 32'h2);
      mask_we = 1'b1; mask_wdata = 4'b1011; int_ack = 1'b1;
      tick();
      chk("s4_ack_int", 32'(INT), 32'h0);
      chk("s4_ack_pend", 32'(pending), 32'h0);
      mask_we = 1'b0; int_ack = 1'b0;
      tick();
      eret = 1'b1;
      tick();
      eret = 1'b0; mask_we = 1'b1; mask_wdata = 4'hF;
      tick();
      mask_we = 1'b0; irq_in = 4'h0;
      tick();
      chk("s4_quiet", 32'(INT), 32'h0);

      // re-rise during ack keeps pending set
      irq_in = 4'b0010;
      tick();
      irq_in = 4'b0000;
      tick();
      chk("s5_int", 32'(INT), 32'h1);
      chk("s5_id", 32'(int_id), 32'h1);
      irq_in = 4'b0010; int_ack = 1'b1;
      tick();
      chk("s5_ack_int", 32'(INT), 32'h0);
      chk("s5_ack_pend", 32'(pending), 32'h2);
      int_ack = 1'b0;
      tick();
      chk("s5_svc", 32'(INT), 32'h0);
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tick();
      chk("s5_again_int", 32'(INT), 32'h1);
      chk("s5_again_id", 32'(int_id), 32'h1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0; eret = 1'b1;
      tick();
      eret = 1'b0; irq_in = 4'h0;
      tick();

      // reset during SERVICE with lines held high
      irq_in = 4'b0001;
      tick();
      tick();
      chk("s6_int", 32'(INT), 32'h1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0; irq_in = 4'hF;
      tick();
      chk("s6_pend", 32'(pending), 32'hE);
      rst = 1'b1; eret = 1'b1;
      tick();
      chk("s6_rst_int", 32'(INT), 32'h0);
      chk("s6_rst_id", 32'(int_id), 32'h0);
      chk("s6_rst_vec", int_vec, 32'h40);
      chk("s6_rst_mask", 32'(mask), 32'hF);
      chk("s6_rst_pend", 32'(pending), 32'h0);
      rst = 1'b0; eret = 1'b0;
      tick();
      chk("s6_post_pend", 32'(pending), 32'h0);
      tick();
      tick();
      chk("s6_post_int", 32'(INT), 32'h0);
      irq_in = 4'h0;
      tick();
      irq_in = 4'b0100;
      tick();
      chk("s6_new_pend", 32'(pending), 32'h4);
      tick();
      chk("s6_new_int", 32'(INT), 32'h1);
      chk("s6_new_id", 32'(int_id), 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
